// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
//
// Write-back buffer between the D-cache and the D-cache port of the L2
// arbiter. Evicted lines are accepted in one cycle and drained downstream in
// FIFO order. Reads that hit a buffered line are answered locally from the
// youngest matching entry. Reads that miss are passed to the arbiter.
//
// Parameters
//   DEPTH              number of 256-bit line entries (power of 2, >= 2)
//
// Optional feature
//   WB_COALESCE_EN     when defined, a write whose tag matches a buffered entry
//                      overwrites that entry's data instead of allocating a new
//                      entry. The entry currently being drained is excluded.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   Dcache_wb_read/write   upstream request, held until wb_Dcache_resp
//   Dcache_wb_addr/wdata   upstream line address (bits [4:0] ignored) / data
//   wb_Dcache_resp/rdata   registered 1-cycle completion pulse / read data
//   wb_arbiter_read/write  registered downstream request, held until resp
//   wb_arbiter_addr/wdata  registered downstream line address / write data
//   arbiter_wb_resp/rdata  downstream completion pulse / read data
//   wb_empty               no buffered entries and no downstream op in flight
// -----------------------------------------------------------------------------
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Dcache_wb_read,
    input  logic         Dcache_wb_write,
    input  logic [31:0]  Dcache_wb_addr,
    input  logic [255:0] Dcache_wb_wdata,
    output logic         wb_Dcache_resp,
    output logic [255:0] wb_Dcache_rdata,
    output logic         wb_arbiter_read,
    output logic         wb_arbiter_write,
    output logic [31:0]  wb_arbiter_addr,
    output logic [255:0] wb_arbiter_wdata,
    input  logic         arbiter_wb_resp,
    input  logic [255:0] arbiter_wb_rdata,
    output logic         wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FILL
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0] valid_q;
    logic [26:0]      tag_q  [DEPTH];
    logic [255:0]     data_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;

    logic [26:0]      req_tag;
    logic             unused_addr_bits;
    logic             req_active, rd_req, wr_req;
    logic             hit;
    logic [PTR_W-1:0] hit_idx, scan_idx;
    logic             rd_hit, rd_miss;
    logic             drain_start, pop, fill_done;
    logic             enq, do_coalesce;

    assign req_tag          = Dcache_wb_addr[31:5];
    assign unused_addr_bits = ^Dcache_wb_addr[4:0];

    // A request still held in the cycle its response is out is the one just
    // served, so it must not be accepted a second time.
    assign req_active = ~wb_Dcache_resp;
    assign rd_req     = Dcache_wb_read  & req_active;
    assign wr_req     = Dcache_wb_write & req_active;

    // Valid entries are contiguous from head, so scanning oldest to youngest
    // and keeping the last match yields the youngest matching entry.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + i[PTR_W-1:0];
            if (valid_q[scan_idx] && (tag_q[scan_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign rd_hit  = rd_req & hit;
    assign rd_miss = rd_req & ~hit;

    // Read misses win over starting a drain, and only get issued from IDLE,
    // so a miss arriving mid-drain waits for that drain to finish.
    assign drain_start = (state_q == ST_IDLE) && !rd_miss && (count_q != '0);
    assign pop         = (state_q == ST_DRAIN) && arbiter_wb_resp;
    assign fill_done   = (state_q == ST_FILL)  && arbiter_wb_resp;

`ifdef WB_COALESCE_EN
    logic             head_busy;
    logic             co_hit;
    logic [PTR_W-1:0] co_idx, co_scan;

    // The head is treated as busy in the cycle its drain starts as well, since
    // its data is being copied to the downstream port in that same cycle and a
    // merge into it would be lost when it is popped.
    assign head_busy = (state_q == ST_DRAIN) || drain_start;

    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        co_scan = '0;
        for (int i = 0; i < DEPTH; i++) begin
            co_scan = head_q + i[PTR_W-1:0];
            if (valid_q[co_scan] && (tag_q[co_scan] == req_tag) &&
                !(head_busy && (co_scan == head_q))) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end

    assign do_coalesce = wr_req & co_hit;
`else
    assign do_coalesce = 1'b0;
`endif

    // A slot freed by a pop only becomes usable the following cycle.
    assign enq = wr_req && !do_coalesce && (count_q != FULL_COUNT);

    assign wb_empty = (count_q == '0) && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_miss) begin
                    state_d = ST_FILL;
                end else if (drain_start) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (arbiter_wb_resp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (arbiter_wb_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, pointers and all registered outputs. Reset throws away
    // every buffered entry and any in-flight downstream operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            valid_q          <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            wb_Dcache_resp   <= 1'b0;
            wb_Dcache_rdata  <= '0;
            wb_arbiter_read  <= 1'b0;
            wb_arbiter_write <= 1'b0;
            wb_arbiter_addr  <= '0;
            wb_arbiter_wdata <= '0;
        end else begin
            state_q <= state_d;

            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, pop};

            wb_Dcache_resp <= enq | do_coalesce | rd_hit | fill_done;
            if (rd_hit) begin
                wb_Dcache_rdata <= data_q[hit_idx];
            end else if (fill_done) begin
                wb_Dcache_rdata <= arbiter_wb_rdata;
            end

            if ((state_q == ST_IDLE) && rd_miss) begin
                wb_arbiter_read <= 1'b1;
                wb_arbiter_addr <= {req_tag, 5'b0};
            end else if (drain_start) begin
                wb_arbiter_write <= 1'b1;
                wb_arbiter_addr  <= {tag_q[head_q], 5'b0};
                wb_arbiter_wdata <= data_q[head_q];
            end
            if (fill_done) begin
                wb_arbiter_read <= 1'b0;
            end
            if (pop) begin
                wb_arbiter_write <= 1'b0;
            end
        end
    end

    // Line storage; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (enq) begin
            tag_q[tail_q]  <= req_tag;
            data_q[tail_q] <= Dcache_wb_wdata;
        end
`ifdef WB_COALESCE_EN
        if (do_coalesce) begin
            data_q[co_idx] <= Dcache_wb_wdata;
        end
`endif
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_write_buffer
//
// Self-checking bench for dcache_write_buffer (DEPTH=4). A behavioural arbiter
// answers downstream requests after a programmable delay (or stalls), and a
// scoreboard queue holds the lines expected to drain, in order. Read results
// are predicted from the same queue (youngest match) or from the arbiter's
// data pattern on a miss. Honours WB_COALESCE_EN in its prediction.
// -----------------------------------------------------------------------------
module tb_dcache_write_buffer;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] data;
    } wr_t;

`ifdef WB_COALESCE_EN
    localparam int DUP_DRAINS = 2;
`else
    localparam int DUP_DRAINS = 3;
`endif

    logic         clk;
    logic         rst;
    logic         Dcache_wb_read;
    logic         Dcache_wb_write;
    logic [31:0]  Dcache_wb_addr;
    logic [255:0] Dcache_wb_wdata;
    logic         wb_Dcache_resp;
    logic [255:0] wb_Dcache_rdata;
    logic         wb_arbiter_read;
    logic         wb_arbiter_write;
    logic [31:0]  wb_arbiter_addr;
    logic [255:0] wb_arbiter_wdata;
    logic         arbiter_wb_resp;
    logic [255:0] arbiter_wb_rdata;
    logic         wb_empty;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    wr_t exp_drain[$];

    bit          arb_stall = 1'b0;
    int          arb_delay = 1;
    int          wait_cnt = 0;
    int          wr_resp_cnt = 0;
    int          rd_resp_cnt = 0;
    int          rd_start_cnt = 0;
    int          rd_start_wr_cnt = 0;
    int          last_wr_resp_cyc = 0;
    int          last_rd_resp_cyc = 0;
    int          last_up_resp_cyc = 0;
    bit          prev_rd = 1'b0;
    logic [31:0] exp_rd_addr = '0;

    dcache_write_buffer #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .Dcache_wb_read   (Dcache_wb_read),
        .Dcache_wb_write  (Dcache_wb_write),
        .Dcache_wb_addr   (Dcache_wb_addr),
        .Dcache_wb_wdata  (Dcache_wb_wdata),
        .wb_Dcache_resp   (wb_Dcache_resp),
        .wb_Dcache_rdata  (wb_Dcache_rdata),
        .wb_arbiter_read  (wb_arbiter_read),
        .wb_arbiter_write (wb_arbiter_write),
        .wb_arbiter_addr  (wb_arbiter_addr),
        .wb_arbiter_wdata (wb_arbiter_wdata),
        .arbiter_wb_resp  (arbiter_wb_resp),
        .arbiter_wb_rdata (arbiter_wb_rdata),
        .wb_empty         (wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] mk_data(input logic [31:0] seed);
        return {4{seed, ~seed}};
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard update for a write: merge or allocate as the DUT should.
    function automatic void model_push(input logic [31:0] addr, input logic [255:0] data);
        wr_t e;
        bit  merged;
        merged = 1'b0;
`ifdef WB_COALESCE_EN
        // Head entry is assumed in flight whenever the queue is non-empty.
        for (int j = exp_drain.size() - 1; j >= 1; j--) begin
            if (!merged && (exp_drain[j].addr[31:5] == addr[31:5])) begin
                exp_drain[j].data = data;
                merged = 1'b1;
            end
        end
`endif
        if (!merged) begin
            e.addr = {addr[31:5], 5'b0};
            e.data = data;
            exp_drain.push_back(e);
        end
    endfunction

    // Predicted read data: youngest buffered match, else the arbiter pattern.
    function automatic logic [255:0] model_read(input logic [31:0] addr);
        for (int j = exp_drain.size() - 1; j >= 0; j--) begin
            if (exp_drain[j].addr[31:5] == addr[31:5]) return exp_drain[j].data;
        end
        return mk_line({addr[31:5], 5'b0});
    endfunction

    task automatic applyStimulus(input bit is_write, input logic [31:0] addr,
                                 input logic [255:0] data, output int cycles,
                                 output logic [255:0] rdata);
        bit got;
        got    = 1'b0;
        cycles = -1;
        rdata  = '0;
        @(negedge clk);
        if (is_write) model_push(addr, data);
        Dcache_wb_addr  = addr;
        Dcache_wb_wdata = data;
        Dcache_wb_read  = ~is_write;
        Dcache_wb_write = is_write;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (wb_Dcache_resp) begin
                got              = 1'b1;
                cycles           = k;
                rdata            = wb_Dcache_rdata;
                last_up_resp_cyc = cyc;
                break;
            end
        end
        Dcache_wb_read  = 1'b0;
        Dcache_wb_write = 1'b0;
        checkOutput("resp_seen", 256'(got), 256'(1'b1));
    endtask

    task automatic wait_empty(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (wb_empty && (exp_drain.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(tag, 256'(ok), 256'(1'b1));
    endtask

    // Behavioural arbiter: one-cycle resp pulse after arb_delay cycles of a
    // held request; drained lines are checked against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            arbiter_wb_resp = 1'b0;
            wait_cnt        = 0;
        end else if (arbiter_wb_resp) begin
            arbiter_wb_resp = 1'b0;
        end else if ((wb_arbiter_write || wb_arbiter_read) && !arb_stall) begin
            if (wait_cnt < arb_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt        = 0;
                arbiter_wb_resp = 1'b1;
                if (wb_arbiter_write) begin
                    if (exp_drain.size() == 0) begin
                        checkOutput("drain_unexpected", 256'(wb_arbiter_write), 256'(1'b0));
                    end else begin
                        e = exp_drain.pop_front();
                        checkOutput("drain_addr", 256'(wb_arbiter_addr), 256'(e.addr));
                        checkOutput("drain_data", wb_arbiter_wdata, e.data);
                    end
                    wr_resp_cnt++;
                    last_wr_resp_cyc = cyc;
                end else begin
                    checkOutput("fill_addr", 256'(wb_arbiter_addr), 256'(exp_rd_addr));
                    arbiter_wb_rdata = mk_line(wb_arbiter_addr);
                    rd_resp_cnt++;
                    last_rd_resp_cyc = cyc;
                end
            end
        end
        if (wb_arbiter_read && !prev_rd) begin
            rd_start_cnt++;
            rd_start_wr_cnt = wr_resp_cnt;
        end
        prev_rd = wb_arbiter_read;
    end

    initial begin
        int           cyc_to;
        logic [255:0] rd;
        logic [255:0] exp_d;
        int           wr0;
        int           rs0;
        int           ack_cyc;
        bit           saw;
        bit           got;

        rst              = 1'b1;
        Dcache_wb_read   = 1'b0;
        Dcache_wb_write  = 1'b0;
        Dcache_wb_addr   = '0;
        Dcache_wb_wdata  = '0;
        arbiter_wb_resp  = 1'b0;
        arbiter_wb_rdata = '0;
        ack_cyc          = 0;

        // Reset, then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_resp",   256'(wb_Dcache_resp),   256'(1'b0));
        checkOutput("rst_rdata",  wb_Dcache_rdata,        256'(0));
        checkOutput("rst_read",   256'(wb_arbiter_read),  256'(1'b0));
        checkOutput("rst_write",  256'(wb_arbiter_write), 256'(1'b0));
        checkOutput("rst_addr",   256'(wb_arbiter_addr),  256'(0));
        checkOutput("rst_wdata",  wb_arbiter_wdata,       256'(0));
        checkOutput("rst_empty",  256'(wb_empty),         256'(1'b1));

        // Single write, drained with a short arbiter delay.
        $display("[TB] single write");
        arb_delay = 1;
        applyStimulus(1'b1, 32'h0000_1040, mk_data(32'hD000_0000), cyc_to, rd);
        checkOutput("wr_ack_latency", 256'(cyc_to), 256'(1));
        wait_empty("single_drained");

        // Fill the buffer with the arbiter stalled, then a fifth write.
        $display("[TB] full buffer");
        arb_delay = 2;
        arb_stall = 1'b1;
        applyStimulus(1'b1, 32'h0000_A000, mk_data(32'hA), cyc_to, rd);
        checkOutput("fill_ack_a", 256'(cyc_to), 256'(1));
        applyStimulus(1'b1, 32'h0000_B000, mk_data(32'hB), cyc_to, rd);
        checkOutput("fill_ack_b", 256'(cyc_to), 256'(1));
        applyStimulus(1'b1, 32'h0000_C000, mk_data(32'hC), cyc_to, rd);
        checkOutput("fill_ack_c", 256'(cyc_to), 256'(1));
        applyStimulus(1'b1, 32'h0000_D000, mk_data(32'hD), cyc_to, rd);
        checkOutput("fill_ack_d", 256'(cyc_to), 256'(1));
        wr0 = wr_resp_cnt;
        @(negedge clk);
        model_push(32'h0000_E000, mk_data(32'hE));
        Dcache_wb_addr  = 32'h0000_E000;
        Dcache_wb_wdata = mk_data(32'hE);
        Dcache_wb_write = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_Dcache_resp) saw = 1'b1;
        end
        checkOutput("full_no_ack", 256'(saw), 256'(1'b0));
        arb_stall = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (wb_Dcache_resp) begin
                got     = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        Dcache_wb_write = 1'b0;
        checkOutput("full_ack_seen", 256'(got), 256'(1'b1));
        checkOutput("full_one_pop_before_ack", 256'(wr_resp_cnt), 256'(wr0 + 1));
        checkOutput("full_ack_after_pop", 256'(ack_cyc), 256'(last_wr_resp_cyc + 2));
        wait_empty("full_drained");

        // Read hit forwarded from the buffer.
        $display("[TB] read hit");
        arb_stall = 1'b1;
        applyStimulus(1'b1, 32'h0000_2000, mk_data(32'hD1), cyc_to, rd);
        rs0   = rd_start_cnt;
        exp_d = model_read(32'h0000_201C);
        applyStimulus(1'b0, 32'h0000_201C, '0, cyc_to, rd);
        checkOutput("hit_latency", 256'(cyc_to), 256'(1));
        checkOutput("hit_data", rd, exp_d);
        checkOutput("hit_data_d1", rd, mk_data(32'hD1));
        checkOutput("hit_no_arb_read", 256'(rd_start_cnt), 256'(rs0));
        arb_stall = 1'b0;
        wait_empty("hit_drained");

        // Read miss arriving while a drain is in flight.
        $display("[TB] read miss during drain");
        arb_stall = 1'b1;
        applyStimulus(1'b1, 32'h0000_6000, mk_data(32'hD4), cyc_to, rd);
        wr0         = wr_resp_cnt;
        exp_rd_addr = 32'h0000_3000;
        exp_d       = model_read(32'h0000_3004);
        fork
            applyStimulus(1'b0, 32'h0000_3004, '0, cyc_to, rd);
            begin
                repeat (5) @(negedge clk);
                checkOutput("miss_waits_read", 256'(wb_arbiter_read), 256'(1'b0));
                checkOutput("miss_waits_write", 256'(wb_arbiter_write), 256'(1'b1));
                arb_stall = 1'b0;
            end
        join
        checkOutput("miss_after_drain", 256'(rd_start_wr_cnt), 256'(wr0 + 1));
        checkOutput("miss_data", rd, exp_d);
        checkOutput("miss_resp_timing", 256'(last_up_resp_cyc), 256'(last_rd_resp_cyc + 1));
        wait_empty("miss_drained");

        // Duplicate tags behind an in-flight drain.
        $display("[TB] duplicate tags");
        arb_stall = 1'b1;
        wr0 = wr_resp_cnt;
        applyStimulus(1'b1, 32'h0000_7000, mk_data(32'hD5), cyc_to, rd);
        applyStimulus(1'b1, 32'h0000_4000, mk_data(32'hD2), cyc_to, rd);
        applyStimulus(1'b1, 32'h0000_4000, mk_data(32'hD3), cyc_to, rd);
        checkOutput("dup_ack_latency", 256'(cyc_to), 256'(1));
        applyStimulus(1'b0, 32'h0000_4000, '0, cyc_to, rd);
        checkOutput("dup_read_d3", rd, mk_data(32'hD3));
        arb_stall = 1'b0;
        wait_empty("dup_drained");
        checkOutput("dup_drain_count", 256'(wr_resp_cnt - wr0), 256'(DUP_DRAINS));

        // Reset in the middle of a stalled drain.
        $display("[TB] reset mid-transaction");
        arb_stall = 1'b1;
        applyStimulus(1'b1, 32'h0000_5000, mk_data(32'hD6), cyc_to, rd);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_write", 256'(wb_arbiter_write), 256'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_write", 256'(wb_arbiter_write), 256'(1'b0));
        checkOutput("mid_rst_empty", 256'(wb_empty), 256'(1'b1));
        rst = 1'b0;
        exp_drain.delete();
        arb_stall = 1'b0;
        wr0 = wr_resp_cnt;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_no_drain", 256'(wr_resp_cnt), 256'(wr0));
        checkOutput("post_rst_write", 256'(wb_arbiter_write), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
